// File: rtl/ex_mem_pipe_reg.sv
// ============================================================================
// ex_mem_pipe_reg
// ----------------------------------------------------------------------------
// EX/MEM pipeline register with valid/ready flow control.
// It captures the EX-stage payload: ALU result, store data, destination
// register, and the WB and MEM control fields. It supports:
//   - back-pressure from the MEM stage (out_ready low holds the entry),
//   - flush-to-bubble,
//   - a saturating counter of stalled cycles.
//
// Optional feature (compile-time macro EX_MEM_SKID_EN):
//   When defined, one skid entry is added behind the main register. in_ready
//   then comes from a flop (skid empty), so there is no combinational path
//   from out_ready to in_ready. When undefined, in_ready is
//   !out_valid || out_ready.
//
// Ports
//   clock                   in   sole clock, rising edge
//   startin                 in   synchronous active-high reset
//   flush                   in   squash contents; entry becomes a bubble
//   in_valid / in_ready     in/out  EX-side handshake
//   alu_result_input        in   DATA_W  ALU result
//   read_data_2_input       in   DATA_W  store data
//   write_register_input    in   REG_W   destination register
//   WB_input / MEM_input    in   WB_W / MEM_W control fields
//   out_valid / out_ready   out/in  MEM-side handshake
//   alu_result_output       out  DATA_W  registered ALU result
//   read_data_2_output      out  DATA_W  registered store data
//   write_register_output   out  REG_W   registered destination
//   WB_output / MEM_output  out  control fields, forced to zero when !out_valid
//   stall_count             out  CNT_W   saturating count of out_valid && !out_ready
// ============================================================================
module ex_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int MEM_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              startin,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result_input,
    input  logic [DATA_W-1:0] read_data_2_input,
    input  logic [REG_W-1:0]  write_register_input,
    input  logic [WB_W-1:0]   WB_input,
    input  logic [MEM_W-1:0]  MEM_input,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result_output,
    output logic [DATA_W-1:0] read_data_2_output,
    output logic [REG_W-1:0]  write_register_output,
    output logic [WB_W-1:0]   WB_output,
    output logic [MEM_W-1:0]  MEM_output,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rd2;
        logic [REG_W-1:0]  wreg;
        logic [WB_W-1:0]   wb;
        logic [MEM_W-1:0]  mem;
    } payload_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    payload_t         w_in;
    logic             w_accept;
    logic             w_xfer;
    payload_t         r_main;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_in     = {alu_result_input, read_data_2_input, write_register_input,
                       WB_input, MEM_input};
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_out_valid && out_ready;

`ifdef EX_MEM_SKID_EN
    payload_t r_skid;
    logic     r_skid_valid;

    // Registered ready: only the skid occupancy decides, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready = !r_skid_valid;

    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (startin) begin
            // NOTE: payload storage is reset as well, because the outputs are
            // required to read zero after reset, not just be marked invalid.
            r_main       <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            // An accepted payload in this cycle is dropped; data fields hold.
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid) begin
            // Main empty implies skid empty, so new data goes straight to main.
            if (w_accept) begin
                r_main      <= w_in;
                r_out_valid <= 1'b1;
            end
        end else if (w_xfer) begin
            if (r_skid_valid) begin
                // Drain the skid into main to keep order; a simultaneous
                // accept refills the skid.
                r_main <= r_skid;
                if (w_accept) begin
                    r_skid <= w_in;
                end else begin
                    r_skid_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_main <= w_in;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Main full and stalled: park the new payload in the skid.
            r_skid       <= w_in;
            r_skid_valid <= 1'b1;
        end
    end
`else
    // Ready whenever the entry is empty or leaving this cycle.
    assign in_ready = !r_out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (startin) begin
            // NOTE: payload storage is reset as well, because the outputs are
            // required to read zero after reset, not just be marked invalid.
            r_main      <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            // An accepted payload in this cycle is dropped; data fields hold.
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_main      <= w_in;
            r_out_valid <= 1'b1;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    // Stall counter: flush does not clear it, only startin does.
    always_ff @(posedge clock) begin
        if (startin) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid             = r_out_valid;
    assign alu_result_output     = r_main.alu;
    assign read_data_2_output    = r_main.rd2;
    assign write_register_output = r_main.wreg;
    // Control fields read as a bubble whenever the entry is not valid.
    assign WB_output             = r_out_valid ? r_main.wb  : '0;
    assign MEM_output            = r_out_valid ? r_main.mem : '0;
    assign stall_count           = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed vector table, hand
// sequences for stall/flush/reset/saturation, and randomized traffic against
// a queue-based reference model. Works with or without EX_MEM_SKID_EN.
module tb_ex_mem_pipe_reg;

    localparam int CNT_W = 16;
`ifdef EX_MEM_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        startin, flush, in_valid, out_ready;
    logic [31:0] alu_in, rd2_in;
    logic [4:0]  wreg_in;
    logic [1:0]  wb_in, mem_in;
    logic        in_ready, out_valid;
    logic [31:0] alu_out, rd2_out;
    logic [4:0]  wreg_out;
    logic [1:0]  wb_out, mem_out;
    logic [15:0] stall_count;

    // Second instance with a narrow counter for the saturation check.
    logic        sat_startin, sat_in_valid, sat_out_ready;
    logic        sat_flush;
    logic        sat_in_ready, sat_out_valid;
    logic [31:0] sat_alu_out, sat_rd2_out;
    logic [4:0]  sat_wreg_out;
    logic [1:0]  sat_wb_out, sat_mem_out;
    logic [2:0]  sat_stall_count;

    ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .WB_W(2), .MEM_W(2), .CNT_W(CNT_W)) u_dut (
        .clock(clock), .startin(startin), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result_input(alu_in), .read_data_2_input(rd2_in),
        .write_register_input(wreg_in), .WB_input(wb_in), .MEM_input(mem_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result_output(alu_out), .read_data_2_output(rd2_out),
        .write_register_output(wreg_out), .WB_output(wb_out), .MEM_output(mem_out),
        .stall_count(stall_count)
    );

    ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .WB_W(2), .MEM_W(2), .CNT_W(3)) u_sat (
        .clock(clock), .startin(sat_startin), .flush(sat_flush),
        .in_valid(sat_in_valid), .in_ready(sat_in_ready),
        .alu_result_input(alu_in), .read_data_2_input(rd2_in),
        .write_register_input(wreg_in), .WB_input(wb_in), .MEM_input(mem_in),
        .out_valid(sat_out_valid), .out_ready(sat_out_ready),
        .alu_result_output(sat_alu_out), .read_data_2_output(sat_rd2_out),
        .write_register_output(sat_wreg_out), .WB_output(sat_wb_out), .MEM_output(sat_mem_out),
        .stall_count(sat_stall_count)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  wreg;
        logic [1:0]  wb;
        logic [1:0]  mem;
    } pl_t;

    typedef struct {
        logic        s, f, v, r;
        logic [31:0] alu;
        logic [1:0]  wb, mem;
        logic        e_rdy;
        logic        e_valid;
        logic [31:0] e_alu;
        logic [1:0]  e_wb, e_mem;
    } vec_t;

    // Reference model: the register contents are just an ordered queue of
    // payloads with capacity 1 (plain) or 2 (skid).
    pl_t q[$];
    pl_t shown;
    int  m_cnt;
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_in_ready();
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    task automatic drive(input logic s, input logic f, input logic v, input logic r,
                         input logic [31:0] alu, input logic [1:0] wb, input logic [1:0] mem);
        startin   = s;
        flush     = f;
        in_valid  = v;
        out_ready = r;
        alu_in    = alu;
        rd2_in    = ~alu;
        wreg_in   = alu[4:0] ^ 5'h15;
        wb_in     = wb;
        mem_in    = mem;
    endtask

    // One clock: capture the offer, advance the model at the edge, settle.
    task automatic tick();
        pl_t  p;
        logic acc;
        #1;
        acc = in_valid && model_in_ready();
        p   = {alu_in, rd2_in, wreg_in, wb_in, mem_in};
        @(posedge clock);
        if (startin) begin
            q.delete();
            shown = '0;
            m_cnt = 0;
        end else begin
            if (q.size() != 0 && !out_ready && m_cnt < (2**CNT_W - 1)) m_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (acc) q.push_back(p);
            end
            if (q.size() != 0) shown = q[0];
        end
        #1;
    endtask

    task automatic check_model(input int cyc);
        logic nonempty;
        nonempty = (q.size() != 0);
        check($sformatf("rnd%0d_out_valid", cyc), out_valid, nonempty);
        check($sformatf("rnd%0d_alu", cyc), alu_out, shown.alu);
        check($sformatf("rnd%0d_rd2", cyc), rd2_out, shown.rd2);
        check($sformatf("rnd%0d_wreg", cyc), wreg_out, shown.wreg);
        check($sformatf("rnd%0d_wb", cyc), wb_out, nonempty ? shown.wb : 2'b00);
        check($sformatf("rnd%0d_mem", cyc), mem_out, nonempty ? shown.mem : 2'b00);
        check($sformatf("rnd%0d_stall", cyc), stall_count, m_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        shown         = '0;
        m_cnt         = 0;
        sat_startin   = 1'b1;
        sat_flush     = 1'b0;
        sat_in_valid  = 1'b0;
        sat_out_ready = 1'b1;

        // ---------------- reset state ----------------
        drive(1, 0, 0, 1, 32'h0, 2'b00, 2'b00);
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_alu", alu_out, 32'h0);
        check("rst_rd2", rd2_out, 32'h0);
        check("rst_wreg", wreg_out, 5'h0);
        check("rst_wb", wb_out, 2'b00);
        check("rst_mem", mem_out, 2'b00);
        check("rst_stall", stall_count, 16'h0);
        check("rst_in_ready", in_ready, 1'b1);

        // ---------------- vector table ----------------
        //          s  f  v  r  alu     wb mem  rdy val e_alu   e_wb e_mem
        vecs[0] = '{1, 0, 0, 1, 32'h0,  0, 0,   1,  0,  32'h0,  0, 0};
        vecs[1] = '{0, 0, 1, 1, 32'h1,  1, 2,   1,  1,  32'h1,  1, 2};
        vecs[2] = '{0, 0, 1, 1, 32'h2,  2, 1,   1,  1,  32'h2,  2, 1};
        vecs[3] = '{0, 0, 1, 1, 32'h3,  3, 3,   1,  1,  32'h3,  3, 3};
        vecs[4] = '{0, 0, 0, 1, 32'h0,  0, 0,   1,  0,  32'h3,  0, 0};
        vecs[5] = '{0, 0, 1, 0, 32'h55, 3, 2,   1,  1,  32'h55, 3, 2};
        vecs[6] = '{0, 1, 0, 1, 32'h0,  0, 0,   1,  0,  32'h55, 0, 0};
        vecs[7] = '{0, 1, 1, 1, 32'h77, 1, 1,   1,  0,  32'h55, 0, 0};
        vecs[8] = '{0, 0, 0, 1, 32'h0,  0, 0,   1,  0,  32'h55, 0, 0};
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].s, vecs[i].f, vecs[i].v, vecs[i].r, vecs[i].alu, vecs[i].wb, vecs[i].mem);
            #1;
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
            tick();
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_alu", i), alu_out, vecs[i].e_alu);
            check($sformatf("vec%0d_wb", i), wb_out, vecs[i].e_wb);
            check($sformatf("vec%0d_mem", i), mem_out, vecs[i].e_mem);
        end
        check("vec_rd2_held", rd2_out, 32'hFFFF_FFAA);
        check("vec_wreg_held", wreg_out, 5'h00);
        check("vec_stall_after_flush", stall_count, 16'h0);

        // ---------------- back-pressure for 5 cycles ----------------
        drive(1, 0, 0, 1, 32'h0, 2'b00, 2'b00);
        tick();
        drive(0, 0, 1, 1, 32'hAAAA_5555, 2'b10, 2'b01);
        tick();
        check("stall_load_valid", out_valid, 1'b1);
        check("stall_load_alu", alu_out, 32'hAAAA_5555);
        drive(0, 0, 1, 0, 32'hBBBB_0001, 2'b01, 2'b11);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall%0d_in_ready", i), in_ready, SKID && (i == 0));
            tick();
            check($sformatf("stall%0d_valid", i), out_valid, 1'b1);
            check($sformatf("stall%0d_alu", i), alu_out, 32'hAAAA_5555);
            check($sformatf("stall%0d_wb", i), wb_out, 2'b10);
        end
        check("stall_count_5", stall_count, 16'd5);
        drive(0, 0, 0, 1, 32'h0, 2'b00, 2'b00);
        #1;
        check("release_in_ready", in_ready, !SKID);
        tick();
`ifdef EX_MEM_SKID_EN
        check("release_skid_valid", out_valid, 1'b1);
        check("release_skid_alu", alu_out, 32'hBBBB_0001);
        check("release_skid_wb", wb_out, 2'b01);
        check("release_skid_in_ready", in_ready, 1'b1);
        tick();
        check("release_drained", out_valid, 1'b0);
        check("release_drained_alu", alu_out, 32'hBBBB_0001);
`else
        check("release_valid", out_valid, 1'b0);
        check("release_alu_held", alu_out, 32'hAAAA_5555);
`endif
        check("release_stall_kept", stall_count, 16'd5);

        // ---------------- flush keeps the stall counter ----------------
        drive(0, 0, 1, 1, 32'h0000_C0DE, 2'b11, 2'b10);
        tick();
        check("fl_pre_wb", wb_out, 2'b11);
        check("fl_pre_mem", mem_out, 2'b10);
        drive(0, 1, 0, 1, 32'h0, 2'b00, 2'b00);
        tick();
        check("fl_valid", out_valid, 1'b0);
        check("fl_wb", wb_out, 2'b00);
        check("fl_mem", mem_out, 2'b00);
        check("fl_alu_held", alu_out, 32'h0000_C0DE);
        check("fl_stall_kept", stall_count, 16'd5);

        // ---------------- flush together with startin ----------------
        drive(0, 0, 1, 0, 32'hDEAD_0000, 2'b11, 2'b01);
        tick();
        check("fs_pre_valid", out_valid, 1'b1);
        drive(1, 1, 1, 0, 32'h1234_5678, 2'b11, 2'b11);
        tick();
        check("fs_valid", out_valid, 1'b0);
        check("fs_alu", alu_out, 32'h0);
        check("fs_rd2", rd2_out, 32'h0);
        check("fs_wreg", wreg_out, 5'h0);
        check("fs_wb", wb_out, 2'b00);
        check("fs_stall", stall_count, 16'h0);
        check("fs_in_ready", in_ready, 1'b1);

        // ---------------- 2-cycle reset mid-stream ----------------
        drive(0, 0, 1, 1, 32'h11, 2'b01, 2'b01);
        tick();
        drive(0, 0, 1, 1, 32'h12, 2'b10, 2'b10);
        tick();
        drive(0, 0, 1, 0, 32'h13, 2'b11, 2'b11);
        tick();
        check("ms_pre_stall", stall_count, 16'd1);
        drive(1, 0, 1, 1, 32'h14, 2'b01, 2'b10);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("ms%0d_valid", i), out_valid, 1'b0);
            check($sformatf("ms%0d_alu", i), alu_out, 32'h0);
            check($sformatf("ms%0d_stall", i), stall_count, 16'h0);
            check($sformatf("ms%0d_in_ready", i), in_ready, 1'b1);
        end
        drive(0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
        #1;
        check("ms_post_in_ready", in_ready, 1'b1);
        tick();

        // ---------------- stall counter saturation (CNT_W=3) ----------------
        drive(0, 0, 0, 1, 32'h99, 2'b01, 2'b01);
        sat_startin = 1'b0;
        sat_in_valid = 1'b1;
        sat_out_ready = 1'b0;
        tick();
        check("sat_load_valid", sat_out_valid, 1'b1);
        check("sat_start", sat_stall_count, 3'd0);
        sat_in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) check("sat_count6", sat_stall_count, 3'd6);
        end
        check("sat_count_max", sat_stall_count, 3'd7);
        check("sat_still_valid", sat_out_valid, 1'b1);

        // ---------------- randomized traffic vs. model ----------------
        drive(1, 0, 0, 1, 32'h0, 2'b00, 2'b00);
        tick();
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(99) == 0, $urandom_range(29) == 0,
                  $urandom_range(9) < 6, $urandom_range(9) < 6,
                  $urandom, 2'($urandom_range(3)), 2'($urandom_range(3)));
            #1;
            check($sformatf("rnd%0d_in_ready", n), in_ready, model_in_ready());
            tick();
            check_model(n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
